// File: rtl/adder_arbiter.sv
// Purpose: shares one BUS_WIDTH-bit adder between NUM_REQ requesters with round-robin grant.
// Latency: one cycle from the transfer edge to rsp_valid; one add per cycle while rsp_ready=1.
// Backpressure: a held result with rsp_ready=0 blocks all grants (req_ready=0) and holds outputs.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   req_valid/req_ready   - per-requester request handshake (req_ready is combinational, one-hot or zero)
//   req_a, req_b          - packed operands, requester i at [i*BUS_WIDTH +: BUS_WIDTH]
//   rsp_valid/rsp_ready   - registered response handshake
//   rsp_sum, rsp_carry    - (a+b) mod 2^BUS_WIDTH and its carry-out
//   rsp_id                - index of the requester that owns the result
module adder_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [BUS_WIDTH-1:0]         rsp_sum,
    output logic                         rsp_carry,
    output logic [ID_WIDTH-1:0]          rsp_id,
    input  logic                         rsp_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       gidx;
    logic [PW:0]         cand;
    logic                found;
    logic [NUM_REQ-1:0]  grant;
    logic                slot_free;
    logic                transfer;
    logic [BUS_WIDTH-1:0] a_sel, b_sel;
    logic [BUS_WIDTH:0]   sum_full;

    // Round-robin search starting at ptr; the candidate index is computed with one
    // extra bit so the wrap back to 0 works for non-power-of-two NUM_REQ.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!found && req_valid[cand[PW-1:0]]) begin
                found                 = 1'b1;
                grant[cand[PW-1:0]]   = 1'b1;
                gidx                  = cand[PW-1:0];
            end
        end
    end

    // The slot can take a new result when empty, or when the held one leaves this cycle.
    assign slot_free = (state_q == EMPTY) || rsp_ready;
    assign req_ready = (slot_free && !reset) ? grant : '0;
    assign transfer  = |req_ready;

    // One-hot AND-OR operand mux keyed by the grant vector.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                a_sel = a_sel | req_a[k*BUS_WIDTH +: BUS_WIDTH];
                b_sel = b_sel | req_b[k*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = FULL;
            ptr_d   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Payload registers load only on a transfer; otherwise they keep the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else if (transfer) begin
            rsp_sum   <= sum_full[BUS_WIDTH-1:0];
            rsp_carry <= sum_full[BUS_WIDTH];
            rsp_id    <= ID_WIDTH'(gidx);
        end
    end

    assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_sum;
    logic         rsp_carry;
    logic [1:0]   rsp_id;
    logic         rsp_ready;

    adder_arbiter #(.BUS_WIDTH(32), .NUM_REQ(4), .ID_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr  = 0;
    bit   m_full = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle from posedge+1, checks the grant against the reference
    // arbiter, pushes the expected result, and pops/compares it after the edge.
    task automatic step(input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                        input logic rr, input string tag, output int gk);
        logic [3:0]  exp_rdy;
        logic [32:0] s;
        exp_t        e;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        exp_rdy = 4'b0000;
        gk      = -1;
        if (!m_full || rr) begin
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (m_ptr + i) % 4;
                if (gk < 0 && v[idx]) gk = idx;
            end
        end
        if (gk >= 0) exp_rdy[gk] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, exp_rdy);
        end
        if (gk >= 0) begin
            s = {1'b0, a[gk*32 +: 32]} + {1'b0, b[gk*32 +: 32]};
            e.sum = s[31:0];
            e.carry = s[32];
            e.id = 2'(gk);
            sb.push_back(e);
            m_ptr  = (gk + 1) % 4;
            m_full = 1;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== m_full) begin
            errors++;
            $display("FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, m_full);
        end
        if (gk >= 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_sum !== e.sum || rsp_carry !== e.carry || rsp_id !== e.id) begin
                errors++;
                $display("FAIL %s result: got sum=%h carry=%b id=%0d expected sum=%h carry=%b id=%0d",
                         tag, rsp_sum, rsp_carry, rsp_id, e.sum, e.carry, e.id);
            end
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_ptr  = 0;
        m_full = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b id=%0d expected all zero",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        reset  = 1'b0;
        m_ptr  = 0;
        m_full = 0;
    endtask

    task automatic test_single();
        logic [127:0] a, b;
        int gk;
        a = '0; b = '0;
        a[2*32 +: 32] = 32'd5;
        b[2*32 +: 32] = 32'd7;
        step(4'b0100, a, b, 1'b1, "single", gk);
        checks++;
        if (rsp_sum !== 32'd12 || rsp_carry !== 1'b0 || rsp_id !== 2'd2 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_const: got v=%b sum=%0d c=%b id=%0d expected v=1 sum=12 c=0 id=2",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        // ptr must now be 3: with everyone valid, requester 3 wins next.
        step(4'b1111, '0, '0, 1'b1, "single_ptr", gk);
        checks++;
        if (gk != 3 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL single_ptr: got grant %0d id=%0d expected 3", gk, rsp_id);
        end
    endtask

    task automatic test_round_robin();
        logic [127:0] a, b;
        int gk;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                a[k*32 +: 32] = 32'(100 * i + k);
                b[k*32 +: 32] = 32'(i * 7 + 1);
            end
            step(4'b1111, a, b, 1'b1, "round_robin", gk);
            checks++;
            if (gk != (i % 4) || rsp_id !== 2'(i % 4) || rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL round_robin_order: cycle %0d got id=%0d v=%b expected id=%0d v=1",
                         i, rsp_id, rsp_valid, i % 4);
            end
        end
    endtask

    task automatic test_overflow();
        logic [127:0] a, b;
        int gk;
        a = '0; b = '0;
        a[31:0] = 32'hFFFF_FFFF;
        b[31:0] = 32'h0000_0002;
        step(4'b0001, a, b, 1'b1, "overflow", gk);
        checks++;
        if (rsp_sum !== 32'h0000_0001 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL overflow_const: got sum=%h c=%b id=%0d expected sum=00000001 c=1 id=0",
                     rsp_sum, rsp_carry, rsp_id);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        int gk;
        a = '0; b = '0;
        a[1*32 +: 32] = 32'd100;
        b[1*32 +: 32] = 32'd23;
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, a, b, 1'b0, "backpressure_hold", gk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 32'h1 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin
                errors++;
                $display("FAIL backpressure_stable: got v=%b sum=%h c=%b id=%0d expected v=1 sum=1 c=1 id=0",
                         rsp_valid, rsp_sum, rsp_carry, rsp_id);
            end
        end
        step(4'b1111, a, b, 1'b1, "backpressure_release", gk);
        checks++;
        if (gk != 1 || rsp_valid !== 1'b1 || rsp_sum !== 32'd123 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL backpressure_release: got v=%b sum=%0d id=%0d expected v=1 sum=123 id=1",
                     rsp_valid, rsp_sum, rsp_id);
        end
    endtask

    task automatic test_async_reset();
        int gk;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got v=%b sum=%h c=%b id=%0d expected all zero",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_req_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_ptr  = 0;
        m_full = 0;
        sb.delete();
        step(4'b1111, '0, '0, 1'b1, "async_reset_first", gk);
        checks++;
        if (gk != 0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_first_grant: got id=%0d expected 0", rsp_id);
        end
    endtask

    task automatic test_dropped_request();
        int gk;
        step(4'b0010, '0, '0, 1'b0, "dropped_blocked", gk);
        step(4'b0000, '0, '0, 1'b1, "dropped_drain", gk);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, '0, '0, 1'b1, "dropped_idle", gk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin
                errors++;
                $display("FAIL dropped_no_response: got v=%b id=%0d expected v=0 id=0",
                         rsp_valid, rsp_id);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_async_reset();
        test_dropped_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one BUS_WIDTH-bit adder between NUM_REQ requesters (e.g. address-calc, PC-increment and branch-target stages), so each stage does not need its own adder.
- Each requester has a valid/ready request channel. Grants use round-robin arbitration.
- One registered response channel returns the sum, the carry and the winner's index.
- Sits between pipeline-stage control logic and the shared adder datapath; the adder is instantiated inside this block.

Parameters:
- BUS_WIDTH, 32, operand and sum width.
- NUM_REQ, 4, number of requesters; legal range 1..16.
- ID_WIDTH, 2, width of rsp_id; must be >= ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i presents operands.
- req_a  input  NUM_REQ*BUS_WIDTH  operand A of requester i in bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_b  input  NUM_REQ*BUS_WIDTH  operand B, same packing.
- req_ready  output  NUM_REQ  one-hot (or zero) grant; combinational.
- rsp_valid  output  1  response register holds an unconsumed result.
- rsp_sum  output  BUS_WIDTH  registered (a+b) mod 2^BUS_WIDTH.
- rsp_carry  output  1  registered carry-out of the addition.
- rsp_id  output  ID_WIDTH  index of the requester that owns the result.
- rsp_ready  input  1  consumer accepts the response this cycle.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, round-robin pointer ptr=0, FSM=EMPTY.
- Reset asserted mid-operation discards any held result and any in-flight grant. req_ready is 0 while reset is high.
- FSM has two states, mirrored by rsp_valid: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- slot_free = (state==EMPTY) | (state==FULL & rsp_ready).
- Arbitration (combinational):
  - If slot_free=0 or req_valid=0, req_ready=0.
  - Otherwise grant the first requester k with req_valid[k]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready is at most one-hot.
  - req_ready must not depend on req_a or req_b.
- Transfer: a transfer happens when req_valid[k] & req_ready[k]. On that edge:
  - rsp_sum <= a_k + b_k, truncated to BUS_WIDTH.
  - rsp_carry <= bit BUS_WIDTH of the full sum.
  - rsp_id <= k.
  - rsp_valid <= 1, FSM -> FULL.
  - ptr <= (k+1) mod NUM_REQ.
- No transfer: ptr unchanged.
  - FULL & rsp_ready & no new transfer: rsp_valid <= 0, FSM -> EMPTY. rsp_sum, rsp_carry and rsp_id hold their last values.
  - FULL & !rsp_ready: all response registers hold and req_ready=0 (backpressure).
- Simultaneous accept and new grant in FULL: the old result is consumed and the new result is loaded on the same edge. rsp_valid stays 1, giving no bubble.
- Latency: one cycle from the transfer edge to rsp_valid=1. Throughput is one add per cycle while rsp_ready=1.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- Requesters may deassert req_valid before being granted; no lock is held. Operands are sampled only on the transfer edge.
- NUM_REQ=1: ptr stays 0 and req_ready[0] = req_valid[0] & slot_free.
- Overflow: the sum wraps modulo 2^BUS_WIDTH; rsp_carry reports the wrap. There is no signed-overflow flag.

Test Plan:
1. Reset, then only req_valid[2]=1 with a=5, b=7 and rsp_ready=1 -> req_ready=0100 the same cycle; next cycle rsp_valid=1, rsp_sum=12, rsp_carry=0, rsp_id=2; ptr=3.
2. All four valid, rsp_ready=1, held for 8 cycles -> grant order 0,1,2,3,0,1,2,3 with one result per cycle and no bubbles.
3. a=32'hFFFF_FFFF, b=32'h0000_0002 -> rsp_sum=32'h0000_0001, rsp_carry=1.
4. Result held with rsp_ready=0 for 3 cycles while req_valid=1111 -> req_ready=0000 and outputs stable. Raising rsp_ready grants the next requester in that same cycle; its result appears next cycle with rsp_valid staying 1.
5. Assert reset asynchronously (mid-cycle) while FULL with rsp_id=1 -> rsp_valid drops to 0 immediately, outputs become zero, and after release the first grant is searched from requester 0.
6. req_valid[1] pulses for one cycle while the slot is blocked, then drops -> no grant to 1 and no response with rsp_id=1.
